// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: carries the decoder control word through ID/EX, EX/MEM and
// MEM/WB. It also detects load-use hazards, inserts bubbles on stall or
// flush, and produces the EX-stage operand forwarding selects.
module pipeline_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [8:0] id_ctrl,
  input  logic       id_valid,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic [4:0] id_rd,
  input  logic       ex_flush,
  output logic       stall,
  output logic       ex_valid,
  output logic       ex_alu_src,
  output logic       ex_branch,
  output logic [1:0] ex_alu_op,
  output logic [4:0] ex_dest,
  output logic       mem_read,
  output logic       mem_write,
  output logic       mem_reg_write,
  output logic       mem_mem_to_reg,
  output logic [4:0] mem_dest,
  output logic       wb_reg_write,
  output logic       wb_mem_to_reg,
  output logic [4:0] wb_dest,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b
);

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  typedef struct packed {
    logic       valid;
    logic       alu_src;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic [1:0] alu_op;
    logic [4:0] dest;
    logic [4:0] rs;
    logic [4:0] rt;
  } idex_t;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic [4:0] dest;
  } exmem_t;

  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic [4:0] dest;
  } memwb_t;

  idex_t  ex_q,  ex_d;
  exmem_t mem_q, mem_d;
  memwb_t wb_q,  wb_d;

  // Decoded fields of the ID word. RegDst and MemtoReg are don't-care unless
  // the instruction writes a register, and stores never use rd, so those bits
  // are masked here before they can reach a stage register.
  logic       id_reg_write;
  logic       id_mem_write;
  logic       id_reg_dst;
  logic       id_mem_to_reg;
  logic       id_uses_rt;
  logic       hazard;

  assign id_reg_write  = id_ctrl[5];
  assign id_mem_write  = id_ctrl[3];
  assign id_reg_dst    = id_ctrl[8] & id_reg_write & ~id_mem_write;
  assign id_mem_to_reg = id_ctrl[6] & id_reg_write;
  assign id_uses_rt    = ~id_ctrl[7] | id_mem_write;

  // Load-use hazard: the load in EX writes a register the ID instruction reads.
  // A taken branch overrides it because the ID instruction is wrong-path.
  always_comb begin
    hazard = ex_q.mem_read && (ex_q.dest != 5'd0) && id_valid &&
             ((ex_q.dest == id_rs) || ((ex_q.dest == id_rt) && id_uses_rt));
    stall  = hazard & ~ex_flush;
  end

  // ID/EX next state: capture the sanitised word, or a bubble on flush/stall/invalid.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    ex_d = '0;
    if (!ex_flush && !stall && id_valid) begin
      ex_d.valid      = 1'b1;
      ex_d.alu_src    = id_ctrl[7];
      ex_d.mem_to_reg = id_mem_to_reg;
      ex_d.reg_write  = id_reg_write;
      ex_d.mem_read   = id_ctrl[4];
      ex_d.mem_write  = id_mem_write;
      ex_d.branch     = id_ctrl[2];
      ex_d.alu_op     = id_ctrl[1:0];
      ex_d.dest       = id_reg_dst ? id_rd : id_rt;
      ex_d.rs         = id_rs;
      ex_d.rt         = id_rt;
    end
  end

  // EX/MEM and MEM/WB simply advance; there is no back-pressure downstream.
  always_comb begin
    mem_d.mem_read   = ex_q.mem_read;
    mem_d.mem_write  = ex_q.mem_write;
    mem_d.reg_write  = ex_q.reg_write;
    mem_d.mem_to_reg = ex_q.mem_to_reg;
    mem_d.dest       = ex_q.dest;
    wb_d.reg_write   = mem_q.reg_write;
    wb_d.mem_to_reg  = mem_q.mem_to_reg;
    wb_d.dest        = mem_q.dest;
  end

  // Stage registers with synchronous reset; reset drops anything in flight.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all stages
    // shift on the same edge regardless of statement order.
    if (rst) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end

  // Forwarding select for one EX source register; EX/MEM beats MEM/WB and $0 never forwards.
  function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                         input logic       valid,
                                         input exmem_t     m,
                                         input memwb_t     w);
    logic [1:0] sel;
    sel = FWD_RF;
    if (valid) begin
      if (m.reg_write && (m.dest != 5'd0) && (m.dest == src))
        sel = FWD_MEM;
      else if (w.reg_write && (w.dest != 5'd0) && (w.dest == src))
        sel = FWD_WB;
    end
    return sel;
  endfunction

  // Operand forwarding selects for the instruction currently in EX.
  always_comb begin
    fwd_a = fwd_sel(ex_q.rs, ex_q.valid, mem_q, wb_q);
    fwd_b = fwd_sel(ex_q.rt, ex_q.valid, mem_q, wb_q);
  end

  assign ex_valid       = ex_q.valid;
  assign ex_alu_src     = ex_q.alu_src;
  assign ex_branch      = ex_q.branch;
  assign ex_alu_op      = ex_q.alu_op;
  assign ex_dest        = ex_q.dest;
  assign mem_read       = mem_q.mem_read;
  assign mem_write      = mem_q.mem_write;
  assign mem_reg_write  = mem_q.reg_write;
  assign mem_mem_to_reg = mem_q.mem_to_reg;
  assign mem_dest       = mem_q.dest;
  assign wb_reg_write   = wb_q.reg_write;
  assign wb_mem_to_reg  = wb_q.mem_to_reg;
  assign wb_dest        = wb_q.dest;

endmodule
